// File: rtl/uart_pkg.sv
// Shared definitions for the UART command parser: FSM state codes,
// error codes and the default start-of-frame marker.
package uart_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_ADDR = 3'd1;
    localparam state_t ST_DATH = 3'd2;
    localparam state_t ST_DATL = 3'd3;
    localparam state_t ST_CHK  = 3'd4;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CHKSUM  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    localparam logic [7:0] SOF_DEFAULT = 8'h55;

    function automatic logic [7:0] frame_chk(input logic [7:0] addr,
                                             input logic [7:0] data_h,
                                             input logic [7:0] data_l);
        return addr ^ data_h ^ data_l;
    endfunction

endpackage

// File: rtl/uart_timeout_cnt.sv
// Inter-byte timeout counter: counts idle cycles while a frame is open and
// pulses expire_o on the cycle the count reaches TIMEOUT_CYCLES-1.
module uart_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic run_i,
    input  logic clear_i,
    output logic expire_o
);

    localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // A clear in the expiry cycle suppresses the pulse: the arriving byte wins.
    assign expire_o = run_i && !clear_i && (r_cnt == CNT_MAX);

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_cnt <= '0;
        end else if (clear_i || !run_i || expire_o) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles SOF/ADDR/DATA_H/DATA_L[/CHK] frames from the UART byte stream and
// offers each good frame as a held command; reports checksum/timeout/overrun.
module uart_cmd_parser
    import uart_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE       = SOF_DEFAULT,
    parameter bit         CHK_ON         = 1'b1,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        datain_valid_i,
    input  logic [7:0]  datain_i,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    output logic [7:0]  cmd_addr_o,
    output logic [15:0] cmd_data_o,
    output logic        err_o,
    output logic [1:0]  err_code_o
);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_addr;
    logic [7:0]  r_data_h;
    logic [7:0]  r_data_l;
    logic        r_cmd_valid;
    logic [7:0]  r_cmd_addr;
    logic [15:0] r_cmd_data;
    logic        r_err;
    logic [1:0]  r_err_code;

    logic        w_expire;
    logic        w_frame_done;
    logic        w_chk_err;
    logic [15:0] w_frame_data;
    logic        w_slot_free;
    logic        w_overrun;
    logic        w_cmd_load;
    logic        w_err_det;
    logic [1:0]  w_err_code;

    uart_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .run_i    (r_state != ST_IDLE),
        .clear_i  (datain_valid_i),
        .expire_o (w_expire)
    );

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (datain_valid_i && datain_i == SOF_BYTE) w_state_next = ST_ADDR;
            ST_ADDR: if (datain_valid_i) w_state_next = ST_DATH;
                     else if (w_expire)  w_state_next = ST_IDLE;
            ST_DATH: if (datain_valid_i) w_state_next = ST_DATL;
                     else if (w_expire)  w_state_next = ST_IDLE;
            ST_DATL: if (datain_valid_i) w_state_next = CHK_ON ? ST_CHK : ST_IDLE;
                     else if (w_expire)  w_state_next = ST_IDLE;
            ST_CHK:  if (datain_valid_i || w_expire) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Without a checksum byte the frame completes on DATA_L, taken straight off the bus.
    always_comb begin
        w_frame_done = 1'b0;
        w_chk_err    = 1'b0;
        w_frame_data = {r_data_h, r_data_l};
        case (r_state)
            ST_DATL: begin
                if (datain_valid_i && !CHK_ON) begin
                    w_frame_done = 1'b1;
                    w_frame_data = {r_data_h, datain_i};
                end
            end
            ST_CHK: begin
                if (datain_valid_i) begin
                    if (datain_i == frame_chk(r_addr, r_data_h, r_data_l)) begin
                        w_frame_done = 1'b1;
                    end else begin
                        w_chk_err = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign w_slot_free = !r_cmd_valid || cmd_ready_i;
    assign w_cmd_load  = w_frame_done && w_slot_free;
    assign w_overrun   = w_frame_done && !w_slot_free;
    assign w_err_det   = w_chk_err || w_expire || w_overrun;
    assign w_err_code  = w_chk_err ? ERR_CHKSUM  :
                         w_expire  ? ERR_TIMEOUT :
                         w_overrun ? ERR_OVERRUN : ERR_NONE;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_addr   <= '0;
            r_data_h <= '0;
            r_data_l <= '0;
        end else if (datain_valid_i) begin
            if (r_state == ST_ADDR) r_addr   <= datain_i;
            if (r_state == ST_DATH) r_data_h <= datain_i;
            if (r_state == ST_DATL) r_data_l <= datain_i;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_cmd_valid <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_data  <= '0;
        end else if (w_cmd_load) begin
            r_cmd_valid <= 1'b1;
            r_cmd_addr  <= r_addr;
            r_cmd_data  <= w_frame_data;
        end else if (cmd_ready_i) begin
            r_cmd_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_err <= w_err_det;
            if (w_err_det) r_err_code <= w_err_code;
        end
    end

    assign cmd_valid_o = r_cmd_valid;
    assign cmd_addr_o  = r_cmd_addr;
    assign cmd_data_o  = r_cmd_data;
    assign err_o       = r_err;
    assign err_code_o  = r_err_code;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed frames with literal expectations, then
// random byte streams checked every cycle against a frame-level reference model.
module tb_uart_cmd_parser;

    localparam int TMO       = 16;
    localparam bit CHK       = 1'b1;
    localparam int FRAME_LEN = CHK ? 5 : 4;

    logic        clk_i;
    logic        resetn_i;
    logic        datain_valid_i;
    logic [7:0]  datain_i;
    logic        cmd_valid_o;
    logic        cmd_ready_i;
    logic [7:0]  cmd_addr_o;
    logic [15:0] cmd_data_o;
    logic        err_o;
    logic [1:0]  err_code_o;

    uart_cmd_parser #(
        .SOF_BYTE       (8'h55),
        .CHK_ON         (CHK),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i          (clk_i),
        .resetn_i       (resetn_i),
        .datain_valid_i (datain_valid_i),
        .datain_i       (datain_i),
        .cmd_valid_o    (cmd_valid_o),
        .cmd_ready_i    (cmd_ready_i),
        .cmd_addr_o     (cmd_addr_o),
        .cmd_data_o     (cmd_data_o),
        .err_o          (err_o),
        .err_code_o     (err_code_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_vec  = 0;
    int n_fail = 0;
    bit rand_ready = 1'b0;
    int rdy_low_w  = 2;

    // Reference model: the open frame is just the list of bytes collected so far.
    logic [7:0]  m_frame[$];
    int          m_gap;
    bit          m_valid;
    logic [7:0]  m_addr;
    logic [15:0] m_data;
    bit          m_err;
    logic [1:0]  m_code;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_frame.delete();
        m_gap   = 0;
        m_valid = 1'b0;
        m_addr  = '0;
        m_data  = '0;
        m_err   = 1'b0;
        m_code  = 2'd0;
    endtask

    task automatic model_step();
        bit done = 1'b0, bad = 1'b0, tmo = 1'b0, ovr = 1'b0;
        logic [7:0] a = '0, h = '0, l = '0;
        if (m_frame.size() == 0) begin
            if (datain_valid_i && datain_i == 8'h55) begin
                m_frame.push_back(datain_i);
                m_gap = 0;
            end
        end else if (datain_valid_i) begin
            m_frame.push_back(datain_i);
            m_gap = 0;
            if (m_frame.size() == FRAME_LEN) begin
                a = m_frame[1];
                h = m_frame[2];
                l = m_frame[3];
                if (!CHK || m_frame[4] == (a ^ h ^ l)) done = 1'b1;
                else                                   bad  = 1'b1;
                m_frame.delete();
            end
        end else begin
            m_gap++;
            if (m_gap >= TMO) begin
                tmo = 1'b1;
                m_frame.delete();
            end
        end
        if (done && (!m_valid || cmd_ready_i)) begin
            m_valid = 1'b1;
            m_addr  = a;
            m_data  = {h, l};
            $display("[%0t] cmd addr=%02h data=%04h", $time, a, {h, l});
        end else if (done) begin
            ovr = 1'b1;
            $display("[%0t] overrun, frame addr=%02h dropped", $time, a);
        end else if (cmd_ready_i) begin
            m_valid = 1'b0;
        end
        m_err = bad || tmo || ovr;
        if (m_err) begin
            m_code = bad ? 2'd1 : (tmo ? 2'd2 : 2'd3);
            if (!ovr) $display("[%0t] error code %0d", $time, m_code);
        end
    endtask

    task automatic cycle(input bit v, input logic [7:0] d, input bit r);
        @(posedge clk_i);
        #1;
        datain_valid_i = v;
        datain_i       = d;
        cmd_ready_i    = rand_ready ? ($urandom_range(0, 7) >= rdy_low_w) : r;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit r);
        cycle(1'b1, b, r);
    endtask

    task automatic idle(input int n, input bit r);
        repeat (n) cycle(1'b0, 8'($urandom), r);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] h,
                              input logic [7:0] l, input logic [7:0] c, input bit r);
        send_byte(8'h55, r);
        send_byte(a, r);
        send_byte(h, r);
        send_byte(l, r);
        send_byte(c, r);
    endtask

    task automatic check_outputs(input bit v, input logic [7:0] a, input logic [15:0] d,
                                 input bit e, input logic [1:0] c, input string tag);
        @(negedge clk_i);
        check({tag, ".cmd_valid"}, 32'(cmd_valid_o), 32'(v));
        if (v) begin
            check({tag, ".cmd_addr"}, 32'(cmd_addr_o), 32'(a));
            check({tag, ".cmd_data"}, 32'(cmd_data_o), 32'(d));
        end
        check({tag, ".err_o"},      32'(err_o),      32'(e));
        check({tag, ".err_code"},   32'(err_code_o), 32'(c));
    endtask

    initial begin
        logic [7:0] exp_chk;
        bit         exp_bad;

        resetn_i       = 1'b0;
        datain_valid_i = 1'b0;
        datain_i       = 8'h00;
        cmd_ready_i    = 1'b0;
        model_reset();

        fork
            forever begin
                @(posedge clk_i or negedge resetn_i);
                if (!resetn_i) model_reset();
                else           model_step();
            end
            forever begin
                @(negedge clk_i);
                check("model.cmd_valid", 32'(cmd_valid_o), 32'(m_valid));
                check("model.err_o",     32'(err_o),       32'(m_err));
                check("model.err_code",  32'(err_code_o),  32'(m_code));
                if (m_valid || !resetn_i) begin
                    check("model.cmd_addr", 32'(cmd_addr_o), 32'(m_addr));
                    check("model.cmd_data", 32'(cmd_data_o), 32'(m_data));
                end
            end
        join_none

        // Reset state
        check_outputs(1'b0, 8'h00, 16'h0000, 1'b0, 2'd0, "reset");
        check("reset.cmd_addr0", 32'(cmd_addr_o), 32'h0);
        check("reset.cmd_data0", 32'(cmd_data_o), 32'h0);
        @(posedge clk_i);
        #1 resetn_i = 1'b1;

        // Good frame, consumer always ready
        send_frame(8'h12, 8'hAB, 8'hCD, 8'h74, 1'b1);
        idle(1, 1'b1);
        check_outputs(1'b1, 8'h12, 16'hABCD, 1'b0, 2'd0, "good");
        idle(1, 1'b1);
        check_outputs(1'b0, 8'h00, 16'h0000, 1'b0, 2'd0, "good_clear");

        // Bad checksum, then a good frame
        send_frame(8'h12, 8'hAB, 8'hCD, 8'h75, 1'b1);
        idle(1, 1'b1);
        check_outputs(1'b0, 8'h00, 16'h0000, 1'b1, 2'd1, "chkerr");
        idle(1, 1'b1);
        check_outputs(1'b0, 8'h00, 16'h0000, 1'b0, 2'd1, "chkerr_hold");
        send_frame(8'h12, 8'hAB, 8'hCD, 8'h74, 1'b1);
        idle(1, 1'b1);
        check_outputs(1'b1, 8'h12, 16'hABCD, 1'b0, 2'd1, "after_chkerr");

        // Inter-byte timeout
        send_byte(8'h55, 1'b1);
        send_byte(8'h12, 1'b1);
        idle(TMO, 1'b1);
        check_outputs(1'b0, 8'h00, 16'h0000, 1'b0, 2'd1, "tmo_edge");
        idle(1, 1'b1);
        check_outputs(1'b0, 8'h00, 16'h0000, 1'b1, 2'd2, "tmo");
        send_frame(8'h01, 8'h00, 8'h02, 8'h03, 1'b1);
        idle(1, 1'b1);
        check_outputs(1'b1, 8'h01, 16'h0002, 1'b0, 2'd2, "after_tmo");
        idle(1, 1'b1);

        // Overrun with consumer stalled, then ready in the final-byte cycle
        send_frame(8'h12, 8'hAB, 8'hCD, 8'h74, 1'b0);
        idle(1, 1'b0);
        check_outputs(1'b1, 8'h12, 16'hABCD, 1'b0, 2'd2, "held");
        send_frame(8'h34, 8'h00, 8'h01, 8'h35, 1'b0);
        idle(1, 1'b0);
        check_outputs(1'b1, 8'h12, 16'hABCD, 1'b1, 2'd3, "overrun");
        send_byte(8'h55, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h35, 1'b1);
        idle(1, 1'b0);
        check_outputs(1'b1, 8'h34, 16'h0001, 1'b0, 2'd3, "ready_in_last");
        idle(1, 1'b1);

        // Junk before SOF; the second 55 is address, not a resync
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_frame(8'h55, 8'h10, 8'h20, 8'h30, 1'b1);
        idle(1, 1'b1);
        exp_chk = 8'h55 ^ 8'h10 ^ 8'h20;
        exp_bad = (exp_chk != 8'h30);
        check_outputs(!exp_bad, 8'h55, 16'h1020, exp_bad, exp_bad ? 2'd1 : 2'd3, "sof_as_addr");

        // Reset mid-frame with a pending command
        send_frame(8'h12, 8'hAB, 8'hCD, 8'h74, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'hAB, 1'b0);
        @(posedge clk_i);
        #1;
        resetn_i       = 1'b0;
        datain_valid_i = 1'b0;
        check_outputs(1'b0, 8'h00, 16'h0000, 1'b0, 2'd0, "mid_reset");
        check("mid_reset.cmd_addr0", 32'(cmd_addr_o), 32'h0);
        check("mid_reset.cmd_data0", 32'(cmd_data_o), 32'h0);
        @(posedge clk_i);
        #1 resetn_i = 1'b1;
        send_frame(8'h77, 8'h12, 8'h34, 8'h51, 1'b1);
        idle(1, 1'b1);
        check_outputs(1'b1, 8'h77, 16'h1234, 1'b0, 2'd0, "after_reset");

        // Random streams with random consumer backpressure
        rand_ready = 1'b1;
        for (int f = 0; f < 300; f++) begin
            logic [7:0] fb [5];
            int len;
            rdy_low_w = (f % 4 == 0) ? 7 : 2;
            if ($urandom_range(0, 3) == 0) send_byte(8'($urandom), 1'b0);
            fb[0] = 8'h55;
            fb[1] = 8'($urandom);
            fb[2] = 8'($urandom);
            fb[3] = 8'($urandom);
            fb[4] = fb[1] ^ fb[2] ^ fb[3];
            if ($urandom_range(0, 4) == 0) fb[4] = fb[4] ^ (8'h01 << $urandom_range(0, 7));
            len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 4)) : 5;
            for (int i = 0; i < len; i++) begin
                send_byte(fb[i], 1'b0);
                if ($urandom_range(0, 9) == 0) idle(int'($urandom_range(TMO - 3, TMO + 1)), 1'b0);
                else                           idle(int'($urandom_range(0, 2)), 1'b0);
            end
            if (len < 5) idle(TMO + 2, 1'b0);
        end

        rand_ready = 1'b0;
        idle(TMO + 4, 1'b1);
        @(negedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
